// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall and taken-branch squash with stretchable length.
// Optional saturating stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REGADDR_WIDTH       = 4,
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [REGADDR_WIDTH-1:0] id_rs,
    input  logic [REGADDR_WIDTH-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     ex_mem_read,
    input  logic [REGADDR_WIDTH-1:0] ex_rt,
    input  logic                     ex_branch_taken,
    output logic                     pc_write,
    output logic                     if_id_write,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     stall_cycles,
    output logic [CNT_WIDTH-1:0]     flush_cycles
`else
    output logic                     busy
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        BFLUSH = 2'd2
    } state_t;

    localparam logic [3:0] LS_RELOAD =
        4'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
    localparam logic [3:0] BF_RELOAD =
        4'((BRANCH_FLUSH_CYCLES > 1) ? BRANCH_FLUSH_CYCLES - 2 : 0);
    localparam logic LS_STRETCH = (LOAD_STALL_CYCLES > 1);
    localparam logic BF_STRETCH = (BRANCH_FLUSH_CYCLES > 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       lu;

    assign lu = ex_mem_read && (ex_rt != '0) &&
                ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        busy        = (state != RUN);

        if (!reset_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            busy        = 1'b0;
            state_next  = RUN;
            cnt_next    = '0;
        end else if (ex_branch_taken) begin
            // A taken branch wins from any state and (re)starts the flush window.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (BF_STRETCH) begin
                state_next = BFLUSH;
                cnt_next   = BF_RELOAD;
            end else begin
                state_next = RUN;
                cnt_next   = '0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (lu) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LS_STRETCH) begin
                            state_next = LSTALL;
                            cnt_next   = LS_RELOAD;
                        end
                    end
                end
                LSTALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (cnt == '0) state_next = RUN;
                    else           cnt_next   = cnt - 4'd1;
                end
                BFLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (cnt == '0) state_next = RUN;
                    else           cnt_next   = cnt - 4'd1;
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (if_id_flush && (flush_cycles != '1))
                flush_cycles <= flush_cycles + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations share one stimulus stream and are compared every
// cycle against a remaining-cycles model; directed literal checks pin that model.
module tb_hazard_ctrl;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, busy}
    logic [4:0] o_a, o_b, o_c;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [1:0]  sc_c, fc_c;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REGADDR_WIDTH(RW), .LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(o_a[4]), .if_id_write(o_a[3]), .if_id_flush(o_a[2]), .id_ex_flush(o_a[1]),
`ifdef HAZARD_PERF_CNT_EN
        .busy(o_a[0]), .stall_cycles(sc_a), .flush_cycles(fc_a)
`else
        .busy(o_a[0])
`endif
    );

    hazard_ctrl #(.REGADDR_WIDTH(RW), .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(o_b[4]), .if_id_write(o_b[3]), .if_id_flush(o_b[2]), .id_ex_flush(o_b[1]),
`ifdef HAZARD_PERF_CNT_EN
        .busy(o_b[0]), .stall_cycles(sc_b), .flush_cycles(fc_b)
`else
        .busy(o_b[0])
`endif
    );

    hazard_ctrl #(.REGADDR_WIDTH(RW), .LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(2), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(o_c[4]), .if_id_write(o_c[3]), .if_id_flush(o_c[2]), .id_ex_flush(o_c[1]),
`ifdef HAZARD_PERF_CNT_EN
        .busy(o_c[0]), .stall_cycles(sc_c), .flush_cycles(fc_c)
`else
        .busy(o_c[0])
`endif
    );

    // Model: per configuration, how many more stall / flush cycles are still owed.
    int lsc[3]  = '{1, 3, 1};
    int bfc[3]  = '{1, 2, 2};
    int cmax[3] = '{65535, 65535, 3};
    int rem_s[3] = '{0, 0, 0};
    int rem_f[3] = '{0, 0, 0};
    int m_sc[3]  = '{0, 0, 0};
    int m_fc[3]  = '{0, 0, 0};

    function automatic logic lu_f();
        return ex_mem_read && (ex_rt != 0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    endfunction

    function automatic logic [4:0] exp_out(input int rs, input int rf);
        logic owed;
        owed = (rs > 0) || (rf > 0);
        if (!reset_n)                      return 5'b00000;
        if (ex_branch_taken || rf > 0)     return {4'b1111, owed};
        if (rs > 0 || lu_f())              return {4'b0001, owed};
        return 5'b11000;
    endfunction

    function automatic logic [4:0] act_out(input int i);
        case (i)
            0:       return o_a;
            1:       return o_b;
            default: return o_c;
        endcase
    endfunction

`ifdef HAZARD_PERF_CNT_EN
    function automatic int act_sc(input int i);
        case (i)
            0:       return int'(sc_a);
            1:       return int'(sc_b);
            default: return int'(sc_c);
        endcase
    endfunction
    function automatic int act_fc(input int i);
        case (i)
            0:       return int'(fc_a);
            1:       return int'(fc_b);
            default: return int'(fc_c);
        endcase
    endfunction
`endif

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                rem_s[i] = 0; rem_f[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [4:0] e;
                e = exp_out(rem_s[i], rem_f[i]);
                if (!e[4] && m_sc[i] < cmax[i]) m_sc[i]++;
                if (e[2] && m_fc[i] < cmax[i])  m_fc[i]++;
                if (ex_branch_taken) begin
                    rem_f[i] = bfc[i] - 1; rem_s[i] = 0;
                end else if (rem_f[i] > 0) rem_f[i]--;
                else if (rem_s[i] > 0)     rem_s[i]--;
                else if (lu_f())           rem_s[i] = lsc[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("outs_cfg%0d", i), int'(act_out(i)), int'(exp_out(rem_s[i], rem_f[i])));
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("stall_cnt_cfg%0d", i), act_sc(i), m_sc[i]);
            chk($sformatf("flush_cnt_cfg%0d", i), act_fc(i), m_fc[i]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic mr, input int ert,
                         input int rs, input logic urs, input int rt, input logic urt);
        ex_branch_taken = br;
        ex_mem_read     = mr;
        ex_rt           = RW'(ert);
        id_rs           = RW'(rs);
        id_uses_rs      = urs;
        id_rt           = RW'(rt);
        id_uses_rt      = urt;
    endtask

    task automatic clr();
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        // Reset forces outputs low even with a branch and a hazard presented.
        tick(); drive(1'b1, 1'b1, 3, 3, 1'b1, 0, 1'b0); #1;
        chk("rst_a", int'(o_a), 5'b00000);
        chk("rst_b", int'(o_b), 5'b00000);
        tick(); clr(); reset_n = 1'b1; #1;
        chk("run_a", int'(o_a), 5'b11000);
        chk("run_b", int'(o_b), 5'b11000);

        // Load-use on rs: single bubble in a, three-cycle stall in b.
        tick(); drive(1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b0); #1;
        chk("lu_rs_a", int'(o_a), 5'b00010);
        chk("lu_rs_b1", int'(o_b), 5'b00010);
        tick(); clr(); #1;
        chk("lu_rs_a_after", int'(o_a), 5'b11000);
        chk("lu_rs_b2", int'(o_b), 5'b00011);
        tick(); #1;
        chk("lu_rs_b3", int'(o_b), 5'b00011);
        tick(); #1;
        chk("lu_rs_b4", int'(o_b), 5'b11000);

        // Register zero and unused-operand matches never stall; a used rt match does.
        tick(); drive(1'b0, 1'b1, 0, 0, 1'b1, 0, 1'b0); #1;
        chk("r0_a", int'(o_a), 5'b11000);
        tick(); drive(1'b0, 1'b1, 5, 0, 1'b0, 5, 1'b0); #1;
        chk("rt_unused_a", int'(o_a), 5'b11000);
        tick(); drive(1'b0, 1'b1, 5, 0, 1'b0, 5, 1'b1); #1;
        chk("lu_rt_a", int'(o_a), 5'b00010);
        tick(); clr();
        tick();
        tick();

        // Branch with simultaneous load-use: flush wins, PC never held.
        tick(); drive(1'b1, 1'b1, 3, 3, 1'b1, 0, 1'b0); #1;
        chk("br_a", int'(o_a), 5'b11110);
        chk("br_b1", int'(o_b), 5'b11110);
        tick(); clr(); #1;
        chk("br_a_after", int'(o_a), 5'b11000);
        chk("br_b2", int'(o_b), 5'b11111);
        tick(); #1;
        chk("br_b3", int'(o_b), 5'b11000);

        // Reset asserted in the second stall cycle abandons the stall.
        tick(); drive(1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b0); #1;
        chk("mid_b1", int'(o_b), 5'b00010);
        tick(); clr(); #1;
        chk("mid_b2", int'(o_b), 5'b00011);
        #1 reset_n = 1'b0; #1;
        chk("mid_rst_b", int'(o_b), 5'b00000);
        tick(); reset_n = 1'b1; #1;
        chk("mid_rel_b", int'(o_b), 5'b11000);
        tick(); #1;
        chk("mid_after_b", int'(o_b), 5'b11000);

        // Two single-bubble stalls and one two-cycle flush on the narrow-counter instance.
        tick(); drive(1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b0);
        tick(); clr();
        tick(); drive(1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b0);
        tick(); clr();
        tick(); drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        tick(); clr();
        tick(); #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_c", int'(sc_c), 2);
        chk("perf_flush_c", int'(fc_c), 2);
`endif
        tick(); drive(1'b0, 1'b1, 3, 3, 1'b1, 0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        clr();
        tick(); #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_sat_c", int'(sc_c), 3);
        chk("perf_flush_hold_c", int'(fc_c), 2);
`endif
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
